life_generation_stepper: RTL

Computes the next Conway's Game of Life generation for a toroidal WIDTH×HEIGHT board, one row per clock. It sits directly upstream of the board-state register. It reads that register's output, snapshots it, and computes the next board row by row. It then drives the register's data input and write-enable for exactly one cycle to commit the new generation.

---
 rtl/life_pkg.sv | 20 ++
 rtl/life_cell_next.sv | 20 ++
 rtl/life_generation_stepper.sv | 98 +++++++++
 3 files changed

// File: rtl/life_pkg.sv
// Shared types and torus-index helpers for the Game of Life generation stepper.
package life_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        COMMIT
    } life_state_t;

    localparam int NBR_CNT_W = 4;

    function automatic int unsigned wrap_dec(input int unsigned idx, input int unsigned size);
        return (idx == 0) ? size - 1 : idx - 1;
    endfunction

    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned size);
        return (idx == size - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/life_cell_next.sv
// Combinational Life rule for one cell: survive on 2 or 3 neighbours, birth on exactly 3.
module life_cell_next
    import life_pkg::*;
(
    input  logic       cell_i,
    input  logic [7:0] nbr_i,
    output logic       alive_o
);

    logic [NBR_CNT_W-1:0] cnt;

    always_comb begin
        cnt = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            cnt = cnt + NBR_CNT_W'(nbr_i[k]);
        end
        alive_o = (cnt == NBR_CNT_W'(3)) || (cell_i && (cnt == NBR_CNT_W'(2)));
    end

endmodule

// File: rtl/life_generation_stepper.sv
// Snapshots the board, computes the next toroidal Life generation one row per clock,
// then pulses board_we for one cycle to commit it into the board register.
module life_generation_stepper
    import life_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [WIDTH*HEIGHT-1:0]   board,
    output logic [WIDTH*HEIGHT-1:0]   next_board,
    output logic                      board_we,
    output logic                      busy,
    output logic                      done,
    output logic [15:0]               generation
);

    localparam int N     = WIDTH * HEIGHT;
    localparam int ROW_W = $clog2(HEIGHT);

    life_state_t      state_q;
    logic [N-1:0]     cur_q;
    logic [N-1:0]     nxt_q;
    logic [ROW_W-1:0] row_q;
    logic [15:0]      gen_q;

    logic [WIDTH-1:0] up_row;
    logic [WIDTH-1:0] mid_row;
    logic [WIDTH-1:0] dn_row;
    logic [WIDTH-1:0] row_next;

    // Three snapshot rows around the active row, wrapped vertically.
    always_comb begin
        int unsigned r;
        r       = 32'(row_q);
        up_row  = cur_q[wrap_dec(r, HEIGHT) * WIDTH +: WIDTH];
        mid_row = cur_q[r * WIDTH +: WIDTH];
        dn_row  = cur_q[wrap_inc(r, HEIGHT) * WIDTH +: WIDTH];
    end

    for (genvar c = 0; c < WIDTH; c++) begin : g_col
        localparam int unsigned CL = wrap_dec(c, WIDTH);
        localparam int unsigned CR = wrap_inc(c, WIDTH);

        life_cell_next u_cell (
            .cell_i  (mid_row[c]),
            .nbr_i   ({up_row[CL], up_row[c], up_row[CR],
                       mid_row[CL], mid_row[CR],
                       dn_row[CL], dn_row[c], dn_row[CR]}),
            .alive_o (row_next[c])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cur_q   <= '0;
            nxt_q   <= '0;
            row_q   <= '0;
            gen_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        cur_q   <= board;
                        row_q   <= '0;
                        state_q <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    nxt_q[32'(row_q) * WIDTH +: WIDTH] <= row_next;
                    if (row_q == ROW_W'(HEIGHT - 1)) begin
                        row_q   <= '0;
                        state_q <= COMMIT;
                    end else begin
                        row_q <= row_q + 1'b1;
                    end
                end
                COMMIT: begin
                    gen_q   <= gen_q + 16'd1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        next_board = nxt_q;
        board_we   = (state_q == COMMIT);
        done       = (state_q == COMMIT);
        busy       = (state_q != IDLE);
        generation = gen_q;
    end

endmodule
